multicycle_control: RTL and testbench

- Moore/Mealy FSM that sequences the shared-ALU, shared-memory multicycle MIPS datapath. It replaces per-instruction combinational decode with a per-cycle control schedule.
- Supported opcodes: R-type, lw, sw, addi, andi, ori, beq, j, jal.
- Takes opcode from the instruction register and a memory-ready handshake. Drives all datapath mux selects and write enables.
- Exposes the current state and a retired-instruction counter for debug.

---
 rtl/multicycle_control.sv | 204 ++++++++++++++++++++
 tb/tb_multicycle_control.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM: per-cycle datapath schedule
// for the shared-ALU/shared-memory datapath.
// Ports:
//   in  clk, reset (async, active-high), opcode[5:0], mem_ready
//   out PC/memory/IR/register-file enables, mux selects
//       (IorD, MemtoReg, RegDst, ALUSrcA/B, ALUOp, PCSource),
//       illegal_op pulse, state[3:0], retired[CNT_W-1:0]
module multicycle_control #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic [1:0]       MemtoReg,
  output logic [1:0]       RegDst,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [1:0]       PCSource,
  output logic             illegal_op,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTEXEC  = 4'd6,
    S_RTWB    = 4'd7,
    S_BRANCH  = 4'd8,
    S_JUMP    = 4'd9,
    S_IMMEXEC = 4'd10,
    S_IMMWB   = 4'd11,
    S_JAL     = 4'd12
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;

  state_t cur, nxt;
  logic   retire;

  logic is_r, is_mem, is_imm;
  logic is_beq, is_j, is_jal;

  always_comb begin
    is_r   = (opcode == OP_R);
    is_mem = (opcode == OP_LW) ||
             (opcode == OP_SW);
    is_imm = (opcode == OP_ADDI) ||
             (opcode == OP_ANDI) ||
             (opcode == OP_ORI);
    is_beq = (opcode == OP_BEQ);
    is_j   = (opcode == OP_J);
    is_jal = (opcode == OP_JAL);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur     <= S_FETCH;
      retired <= '0;
    end else begin
      cur <= nxt;
      if (retire)
        retired <= retired + 1'b1;
    end
  end

  assign state = cur;

  always_comb begin
    nxt         = S_FETCH;
    retire      = 1'b0;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 2'b00;
    RegDst      = 2'b00;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ALUOp       = 2'b00;
    PCSource    = 2'b00;
    illegal_op  = 1'b0;
    unique case (cur)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        // Mealy: latch IR and PC+4 only
        // on the cycle memory delivers.
        IRWrite = mem_ready & ~reset;
        PCWrite = mem_ready & ~reset;
        nxt     = mem_ready ? S_DECODE
                            : S_FETCH;
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
        unique case (1'b1)
          is_r:    nxt = S_RTEXEC;
          is_mem:  nxt = S_MEMADR;
          is_imm:  nxt = S_IMMEXEC;
          is_beq:  nxt = S_BRANCH;
          is_j:    nxt = S_JUMP;
          is_jal:  nxt = S_JAL;
          default: begin
            nxt        = S_FETCH;
            illegal_op = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        nxt     = (opcode == OP_LW) ? S_MEMRD
                                    : S_MEMWR;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        nxt     = mem_ready ? S_MEMWB
                            : S_MEMRD;
      end
      S_MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 2'b01;
        retire   = 1'b1;
      end
      S_MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        nxt      = mem_ready ? S_FETCH
                             : S_MEMWR;
        retire   = mem_ready;
      end
      S_RTEXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
        nxt     = S_RTWB;
      end
      S_RTWB: begin
        RegWrite = 1'b1;
        RegDst   = 2'b01;
        retire   = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
        retire      = 1'b1;
      end
      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
        retire   = 1'b1;
      end
      S_IMMEXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        ALUOp   = (opcode == OP_ADDI) ? 2'b00
                                      : 2'b11;
        nxt     = S_IMMWB;
      end
      S_IMMWB: begin
        RegWrite = 1'b1;
        retire   = 1'b1;
      end
      S_JAL: begin
        // PC already holds PC+4: that is
        // the return address for $31.
        PCWrite  = 1'b1;
        PCSource = 2'b10;
        RegWrite = 1'b1;
        RegDst   = 2'b10;
        MemtoReg = 2'b10;
        retire   = 1'b1;
      end
      default: nxt = S_FETCH;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: expected
// per-cycle state/controls queued, then compared.
module tb_multicycle_control;

  typedef struct packed {
    logic       pcw, pcwc, iord, mrd, mwr, irw;
    logic [1:0] m2r, rdst;
    logic       rw, srca;
    logic [1:0] srcb, aluop, pcsrc;
    logic       ill;
  } ctl_t;

  typedef struct {
    logic [3:0]  st;
    logic        mr;
    ctl_t        ctl;
    logic [31:0] ret;
  } exp_t;

  logic clk, reset, mem_ready;
  logic [5:0] opcode;
  logic pcw, pcwc, iord, mrd, mwr, irw;
  logic [1:0] m2r, rdst, srcb, aluop, pcsrc;
  logic rw, srca, ill;
  logic [3:0] st;
  logic [31:0] ret;
  logic pcw4, pcwc4, iord4, mrd4, mwr4, irw4;
  logic [1:0] m2r4, rdst4, srcb4, aluop4, pcsrc4;
  logic rw4, srca4, ill4;
  logic [3:0] st4, ret4;

  int n_cmp, n_bad;
  logic [31:0] exp_ret;
  exp_t sb[$];

  multicycle_control dut (
    .clk(clk), .reset(reset),
    .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(pcw), .PCWriteCond(pcwc),
    .IorD(iord), .MemRead(mrd),
    .MemWrite(mwr), .IRWrite(irw),
    .MemtoReg(m2r), .RegDst(rdst),
    .RegWrite(rw), .ALUSrcA(srca),
    .ALUSrcB(srcb), .ALUOp(aluop),
    .PCSource(pcsrc), .illegal_op(ill),
    .state(st), .retired(ret)
  );

  multicycle_control #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset),
    .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(pcw4), .PCWriteCond(pcwc4),
    .IorD(iord4), .MemRead(mrd4),
    .MemWrite(mwr4), .IRWrite(irw4),
    .MemtoReg(m2r4), .RegDst(rdst4),
    .RegWrite(rw4), .ALUSrcA(srca4),
    .ALUSrcB(srcb4), .ALUOp(aluop4),
    .PCSource(pcsrc4), .illegal_op(ill4),
    .state(st4), .retired(ret4)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h",
               tag, obs, exp);
    end
  endtask

  function automatic logic legal(input logic [5:0] op);
    case (op)
      6'b000000, 6'b100011, 6'b101011,
      6'b001000, 6'b001100, 6'b001101,
      6'b000100, 6'b000010, 6'b000011:
        legal = 1'b1;
      default: legal = 1'b0;
    endcase
  endfunction

  function automatic ctl_t ectl(input logic [3:0] s,
                                input logic [5:0] op,
                                input logic mr);
    ctl_t c;
    c = '0;
    case (s)
      4'd0: begin
        c.mrd = 1; c.srcb = 2'b01;
        c.irw = mr; c.pcw = mr;
      end
      4'd1: begin
        c.srcb = 2'b11; c.ill = ~legal(op);
      end
      4'd2: begin c.srca = 1; c.srcb = 2'b10; end
      4'd3: begin c.mrd = 1; c.iord = 1; end
      4'd4: begin c.rw = 1; c.m2r = 2'b01; end
      4'd5: begin c.mwr = 1; c.iord = 1; end
      4'd6: begin c.srca = 1; c.aluop = 2'b10; end
      4'd7: begin c.rw = 1; c.rdst = 2'b01; end
      4'd8: begin
        c.srca = 1; c.aluop = 2'b01;
        c.pcwc = 1; c.pcsrc = 2'b01;
      end
      4'd9: begin c.pcw = 1; c.pcsrc = 2'b10; end
      4'd10: begin
        c.srca = 1; c.srcb = 2'b10;
        c.aluop = (op == 6'b001000) ? 2'b00
                                    : 2'b11;
      end
      4'd11: c.rw = 1;
      4'd12: begin
        c.pcw = 1; c.pcsrc = 2'b10; c.rw = 1;
        c.rdst = 2'b10; c.m2r = 2'b10;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  task automatic push(input logic [3:0] s,
                      input logic mr,
                      input logic [5:0] op);
    exp_t e;
    e.st  = s;
    e.mr  = mr;
    e.ctl = ectl(s, op, mr);
    e.ret = exp_ret;
    sb.push_back(e);
  endtask

  task automatic pop_cmp(input logic [5:0] op);
    exp_t e;
    ctl_t o, o4;
    e = sb.pop_front();
    @(negedge clk);
    opcode    = op;
    mem_ready = e.mr;
    #1;
    o  = '{pcw, pcwc, iord, mrd, mwr, irw, m2r,
           rdst, rw, srca, srcb, aluop, pcsrc, ill};
    o4 = '{pcw4, pcwc4, iord4, mrd4, mwr4, irw4,
           m2r4, rdst4, rw4, srca4, srcb4, aluop4,
           pcsrc4, ill4};
    check("state", {28'd0, st}, {28'd0, e.st});
    check("ctl", {13'd0, o}, {13'd0, e.ctl});
    check("retired", ret, e.ret);
    check("ret4", {28'd0, ret4},
          {28'd0, e.ret[3:0]});
    check("ctl4", {13'd0, o4}, {13'd0, e.ctl});
  endtask

  // fw: fetch wait cycles; mw: memory wait
  // cycles; stop >= 0 pops only that many.
  task automatic run(input logic [5:0] op,
                     input int fw, input int mw,
                     input int stop);
    int n;
    for (int i = 0; i < fw; i++) push(0, 0, op);
    push(0, 1, op);
    push(1, 1'($urandom), op);
    case (op)
      6'b000000: begin
        push(6, 1'($urandom), op);
        push(7, 1'($urandom), op);
      end
      6'b100011: begin
        push(2, 1'($urandom), op);
        for (int i = 0; i < mw; i++) push(3, 0, op);
        push(3, 1, op);
        push(4, 1'($urandom), op);
      end
      6'b101011: begin
        push(2, 1'($urandom), op);
        for (int i = 0; i < mw; i++) push(5, 0, op);
        push(5, 1, op);
      end
      6'b001000, 6'b001100, 6'b001101: begin
        push(10, 1'($urandom), op);
        push(11, 1'($urandom), op);
      end
      6'b000100: push(8, 1'($urandom), op);
      6'b000010: push(9, 1'($urandom), op);
      6'b000011: push(12, 1'($urandom), op);
      default: ;
    endcase
    n = (stop >= 0) ? stop : sb.size();
    for (int i = 0; i < n; i++) pop_cmp(op);
    if (stop < 0 && legal(op)) exp_ret++;
  endtask

  logic [5:0] ops [9];

  initial begin
    n_cmp = 0; n_bad = 0; exp_ret = 0;
    ops = '{6'b000000, 6'b100011, 6'b101011,
            6'b001000, 6'b001100, 6'b001101,
            6'b000100, 6'b000010, 6'b000011};
    reset = 1'b1; mem_ready = 1'b1;
    opcode = 6'b000000;
    @(negedge clk); @(negedge clk);
    #1;
    check("rst_state", {28'd0, st}, 32'd0);
    check("rst_ret", ret, 32'd0);
    check("rst_pcw", {31'd0, pcw}, 32'd0);
    check("rst_irw", {31'd0, irw}, 32'd0);
    check("rst_mrd", {31'd0, mrd}, 32'd1);
    reset = 1'b0; mem_ready = 1'b0;

    run(6'b000000, 0, 0, -1);
    run(6'b100011, 0, 2, -1);
    run(6'b101011, 0, 0, -1);
    run(6'b001101, 0, 0, -1);
    run(6'b001100, 1, 0, -1);
    run(6'b001000, 0, 0, -1);
    run(6'b000011, 0, 0, -1);
    run(6'b000100, 0, 0, -1);
    run(6'b000010, 0, 0, -1);
    run(6'b111111, 0, 0, -1);
    run(6'b000000, 3, 0, -1);
    run(6'b101011, 2, 1, -1);

    // abort a store while MEMWR waits
    run(6'b101011, 0, 5, 5);
    sb.delete();
    #2 reset = 1'b1;
    #1;
    check("ab_state", {28'd0, st}, 32'd0);
    check("ab_mwr", {31'd0, mwr}, 32'd0);
    check("ab_rw", {31'd0, rw}, 32'd0);
    check("ab_ret", ret, 32'd0);
    check("ab_ret4", {28'd0, ret4}, 32'd0);
    mem_ready = 1'b1;
    #1;
    check("ab_pcw", {31'd0, pcw}, 32'd0);
    check("ab_irw", {31'd0, irw}, 32'd0);
    reset = 1'b0; mem_ready = 1'b0;
    exp_ret = 0;

    // wrap the 4-bit counter and beyond
    for (int k = 0; k < 18; k++)
      run(ops[$urandom_range(8)],
          $urandom_range(1), $urandom_range(2), -1);

    @(negedge clk);
    #1;
    check("wrap_ret", ret, exp_ret);
    check("wrap_ret4", {28'd0, ret4},
          {28'd0, exp_ret[3:0]});
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got hang want finish");
    $fatal(1);
  end

endmodule
